// File: rtl/if_fetch.sv
// Instruction fetch stage: PC register plus an IDLE/BUSY/HOLD bus FSM feeding IF/ID.
// Optional macro IF_ALIGN_CHECK_EN traps misaligned PCs in IDLE instead of fetching.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] pc,
  output logic [31:0] inst_o,
  output logic [31:0] excepttype_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] EXC_ADEL = 32'h00002000;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_inst_buf;

  logic        w_ack;
  logic        w_align_fault;
  logic        w_issue;
  logic        w_advance;
  logic [31:0] w_pc_next;
  logic [31:0] w_fetch_addr;
  logic        w_unused_ok;

  // Acks only count while our own request is outstanding.
  assign w_ack = (r_state == BUSY) && r_mem_req && mem_ack_i;

`ifdef IF_ALIGN_CHECK_EN
  assign w_align_fault = (r_pc[1:0] != 2'b00);
`else
  assign w_align_fault = 1'b0;
`endif

  assign w_fetch_addr = {r_pc[31:2], 2'b00};
  assign w_issue      = (r_state == IDLE) && !w_align_fault;
  assign w_advance    = ((r_state == BUSY) && w_ack && !stall[0]) ||
                        ((r_state == HOLD) && !stall[0]);
  assign w_pc_next    = branch_flag_i ? branch_target_address_i : (r_pc + 32'd4);

  // IF/ID holding (stall[1]) and the later stall bits belong to other stages.
  assign w_unused_ok = ^stall[5:1];

  assign pc         = r_pc;
  assign mem_req_o  = r_mem_req;
  assign mem_addr_o = r_mem_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (!w_align_fault) w_next_state = BUSY;
        BUSY:    if (w_ack) w_next_state = stall[0] ? HOLD : IDLE;
        HOLD:    if (!stall[0]) w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq_o   = 1'b0;
    inst_o       = 32'h0;
    excepttype_o = 32'h0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          stallreq_o = !w_align_fault;
          if (w_align_fault) excepttype_o = EXC_ADEL;
        end
        BUSY: begin
          stallreq_o = !w_ack;
          if (w_ack) inst_o = mem_data_i;
        end
        HOLD: begin
          inst_o = r_inst_buf;
        end
        default: begin
          stallreq_o = 1'b0;
        end
      endcase
    end
  end

  // Flush outranks stall, branch and ack; a flushed ack never reaches inst_buf.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'h0;
      r_inst_buf <= 32'h0;
    end else if (flush) begin
      r_pc       <= new_pc;
      r_mem_req  <= 1'b0;
      r_inst_buf <= 32'h0;
    end else begin
      if (w_issue) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= w_fetch_addr;
      end
      if (w_ack) begin
        r_mem_req  <= 1'b0;
        r_inst_buf <= mem_data_i;
      end
      if (w_advance) begin
        r_pc <= w_pc_next;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scenario bench for if_fetch: expected bus addresses and instructions queue up as
// stimulus is driven and are popped when the fetch stage presents them.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic [31:0] pc;
  logic [31:0] inst_o;
  logic [31:0] excepttype_o;
  logic        stallreq_o;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] modelPc;
  logic [31:0] expAddrQ[$];
  logic [31:0] expInstQ[$];
  logic [31:0] expA;
  logic [31:0] expI;

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .flush(flush),
    .new_pc(new_pc),
    .branch_flag_i(branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i),
    .pc(pc),
    .inst_o(inst_o),
    .excepttype_o(excepttype_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 6'b0; flush = 1'b0; new_pc = 32'h0;
    branch_flag_i = 1'b0; branch_target_address_i = 32'h0;
    mem_ack_i = 1'b0; mem_data_i = 32'h0;
    next(); next(); settle();
    vectors++;
    if (pc !== RESET_PC) begin
      miscompares++; $display("[TB] FAIL reset_pc: got %h, want %h", pc, RESET_PC);
    end
    vectors++;
    if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_bus: got req=%0b addr=%h, want req=0 addr=0", mem_req_o, mem_addr_o);
    end
    vectors++;
    if (inst_o !== 32'h0 || stallreq_o !== 1'b0 || excepttype_o !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outs: got inst=%h stallreq=%0b exc=%h, want 0 0 0", inst_o, stallreq_o, excepttype_o);
    end
    modelPc = RESET_PC;
    next(); rst = 1'b0; settle();
    vectors++;
    if (stallreq_o !== 1'b1 || mem_req_o !== 1'b0 || inst_o !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: got stallreq=%0b req=%0b inst=%h, want 1 0 0", stallreq_o, mem_req_o, inst_o);
    end
  endtask

  task automatic test_basic();
    expAddrQ.push_back({modelPc[31:2], 2'b00});
    next(); settle();
    expA = expAddrQ.pop_front();
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== expA) begin
      miscompares++;
      $display("[TB] FAIL basic_req: got req=%0b addr=%h, want req=1 addr=%h", mem_req_o, mem_addr_o, expA);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h24010001; expInstQ.push_back(32'h24010001);
    #1;
    expI = expInstQ.pop_front();
    vectors++;
    if (inst_o !== expI || stallreq_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_inst: got inst=%h stallreq=%0b, want inst=%h stallreq=0", inst_o, stallreq_o, expI);
    end
    modelPc = modelPc + 32'd4;
    next(); mem_ack_i = 1'b0; settle();
    vectors++;
    if (pc !== modelPc || mem_req_o !== 1'b0 || stallreq_o !== 1'b1 || inst_o !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL basic_idle: got pc=%h req=%0b stallreq=%0b inst=%h, want pc=%h 0 1 0", pc, mem_req_o, stallreq_o, inst_o, modelPc);
    end
    expAddrQ.push_back({modelPc[31:2], 2'b00});
    next(); settle();
    expA = expAddrQ.pop_front();
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== expA) begin
      miscompares++;
      $display("[TB] FAIL basic_next_req: got req=%0b addr=%h, want req=1 addr=%h", mem_req_o, mem_addr_o, expA);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h24020002; expInstQ.push_back(32'h24020002);
    #1;
    expI = expInstQ.pop_front();
    vectors++;
    if (inst_o !== expI) begin
      miscompares++; $display("[TB] FAIL basic_next_inst: got %h, want %h", inst_o, expI);
    end
    modelPc = modelPc + 32'd4;
    next(); mem_ack_i = 1'b0; settle();
  endtask

  task automatic test_delayed_ack();
    expAddrQ.push_back({modelPc[31:2], 2'b00});
    next(); settle();
    expA = expAddrQ.pop_front();
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== expA) begin
      miscompares++;
      $display("[TB] FAIL delay_req: got req=%0b addr=%h, want req=1 addr=%h", mem_req_o, mem_addr_o, expA);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (stallreq_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== expA || pc !== modelPc || inst_o !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL delay_wait%0d: got stallreq=%0b req=%0b addr=%h pc=%h inst=%h, want 1 1 %h %h 0",
                 i, stallreq_o, mem_req_o, mem_addr_o, pc, inst_o, expA, modelPc);
      end
      next(); settle();
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h8C220004; expInstQ.push_back(32'h8C220004);
    #1;
    expI = expInstQ.pop_front();
    vectors++;
    if (inst_o !== expI || stallreq_o !== 1'b0 || pc !== modelPc) begin
      miscompares++;
      $display("[TB] FAIL delay_ack: got inst=%h stallreq=%0b pc=%h, want %h 0 %h", inst_o, stallreq_o, pc, expI, modelPc);
    end
    modelPc = modelPc + 32'd4;
    next(); mem_ack_i = 1'b0; settle();
    vectors++;
    if (pc !== modelPc || mem_req_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL delay_advance: got pc=%h req=%0b, want pc=%h req=0", pc, mem_req_o, modelPc);
    end
  endtask

  task automatic test_hold();
    expAddrQ.push_back({modelPc[31:2], 2'b00});
    next(); settle();
    expA = expAddrQ.pop_front();
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== expA) begin
      miscompares++;
      $display("[TB] FAIL hold_req: got req=%0b addr=%h, want req=1 addr=%h", mem_req_o, mem_addr_o, expA);
    end
    stall = 6'b000111; mem_ack_i = 1'b1; mem_data_i = 32'hAC430008; expInstQ.push_back(32'hAC430008);
    #1;
    vectors++;
    if (inst_o !== expInstQ[0]) begin
      miscompares++; $display("[TB] FAIL hold_ack_inst: got %h, want %h", inst_o, expInstQ[0]);
    end
    for (int i = 0; i < 3; i++) begin
      next(); mem_ack_i = 1'b0; mem_data_i = 32'h0;
      if (i == 2) stall = 6'b0;
      settle();
      vectors++;
      if (stallreq_o !== 1'b0 || mem_req_o !== 1'b0 || inst_o !== expInstQ[0] || pc !== modelPc) begin
        miscompares++;
        $display("[TB] FAIL hold_cycle%0d: got stallreq=%0b req=%0b inst=%h pc=%h, want 0 0 %h %h",
                 i, stallreq_o, mem_req_o, inst_o, pc, expInstQ[0], modelPc);
      end
    end
    expI = expInstQ.pop_front();
    modelPc = modelPc + 32'd4;
    next(); settle();
    vectors++;
    if (pc !== modelPc || stallreq_o !== 1'b1 || inst_o !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL hold_release: got pc=%h stallreq=%0b inst=%h, want %h 1 0 (last %h)", pc, stallreq_o, inst_o, modelPc, expI);
    end
  endtask

  task automatic test_flush();
    expAddrQ.push_back({modelPc[31:2], 2'b00});
    next(); settle();
    expA = expAddrQ.pop_front();
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== expA) begin
      miscompares++;
      $display("[TB] FAIL flush_req: got req=%0b addr=%h, want req=1 addr=%h", mem_req_o, mem_addr_o, expA);
    end
    flush = 1'b1; new_pc = 32'hBFC00380; mem_ack_i = 1'b1; mem_data_i = 32'hDEADBEEF;
    modelPc = 32'hBFC00380;
    next(); flush = 1'b0; mem_ack_i = 1'b0; settle();
    vectors++;
    if (pc !== modelPc || mem_req_o !== 1'b0 || stallreq_o !== 1'b1 || inst_o !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL flush_idle: got pc=%h req=%0b stallreq=%0b inst=%h, want %h 0 1 0", pc, mem_req_o, stallreq_o, inst_o, modelPc);
    end
    expAddrQ.push_back({modelPc[31:2], 2'b00});
    next(); settle();
    expA = expAddrQ.pop_front();
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== expA) begin
      miscompares++;
      $display("[TB] FAIL flush_redirect: got req=%0b addr=%h, want req=1 addr=%h", mem_req_o, mem_addr_o, expA);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h3C1A8000; expInstQ.push_back(32'h3C1A8000);
    #1;
    expI = expInstQ.pop_front();
    vectors++;
    if (inst_o !== expI) begin
      miscompares++; $display("[TB] FAIL flush_handler_inst: got %h, want %h", inst_o, expI);
    end
    modelPc = modelPc + 32'd4;
    next(); mem_ack_i = 1'b0; settle();
  endtask

  task automatic test_branch();
    expAddrQ.push_back({modelPc[31:2], 2'b00});
    next(); settle();
    expA = expAddrQ.pop_front();
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== expA) begin
      miscompares++;
      $display("[TB] FAIL branch_req: got req=%0b addr=%h, want req=1 addr=%h", mem_req_o, mem_addr_o, expA);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h1000FFFF; branch_flag_i = 1'b1; branch_target_address_i = 32'h80000010;
    modelPc = 32'h80000010;
    next(); mem_ack_i = 1'b0; branch_flag_i = 1'b0; settle();
    vectors++;
    if (pc !== modelPc) begin
      miscompares++; $display("[TB] FAIL branch_pc: got %h, want %h", pc, modelPc);
    end
    expAddrQ.push_back({modelPc[31:2], 2'b00});
    next(); settle();
    expA = expAddrQ.pop_front();
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== expA) begin
      miscompares++;
      $display("[TB] FAIL branch_target_req: got req=%0b addr=%h, want req=1 addr=%h", mem_req_o, mem_addr_o, expA);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h00000000;
    modelPc = modelPc + 32'd4;
    next(); mem_ack_i = 1'b0; settle();
  endtask

  // Ends with a request outstanding so the reset test can abandon it.
  task automatic test_wrap();
    flush = 1'b1; new_pc = 32'hFFFFFFFC; modelPc = 32'hFFFFFFFC;
    next(); flush = 1'b0; settle();
    expAddrQ.push_back({modelPc[31:2], 2'b00});
    next(); settle();
    expA = expAddrQ.pop_front();
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== expA) begin
      miscompares++;
      $display("[TB] FAIL wrap_req: got req=%0b addr=%h, want req=1 addr=%h", mem_req_o, mem_addr_o, expA);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h11112222;
    modelPc = modelPc + 32'd4;
    next(); mem_ack_i = 1'b0; settle();
    vectors++;
    if (pc !== modelPc) begin
      miscompares++; $display("[TB] FAIL wrap_pc: got %h, want %h", pc, modelPc);
    end
    expAddrQ.push_back({modelPc[31:2], 2'b00});
    next(); settle();
    expA = expAddrQ.pop_front();
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== expA) begin
      miscompares++;
      $display("[TB] FAIL wrap_zero_req: got req=%0b addr=%h, want req=1 addr=%h", mem_req_o, mem_addr_o, expA);
    end
  endtask

  task automatic test_reset_mid_busy();
    rst = 1'b1; flush = 1'b1; new_pc = 32'h12345678; stall = 6'b000001;
    mem_ack_i = 1'b1; mem_data_i = 32'hCAFEF00D;
    #1;
    vectors++;
    if (inst_o !== 32'h0 || stallreq_o !== 1'b0 || excepttype_o !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL rst_comb: got inst=%h stallreq=%0b exc=%h, want 0 0 0", inst_o, stallreq_o, excepttype_o);
    end
    modelPc = RESET_PC;
    next(); rst = 1'b0; flush = 1'b0; stall = 6'b0; settle();
    vectors++;
    if (pc !== modelPc || mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || inst_o !== 32'h0 || stallreq_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_abandon: got pc=%h req=%0b addr=%h inst=%h stallreq=%0b, want %h 0 0 0 1",
               pc, mem_req_o, mem_addr_o, inst_o, stallreq_o, modelPc);
    end
    expAddrQ.push_back({modelPc[31:2], 2'b00});
    next(); mem_ack_i = 1'b0; settle();
    expA = expAddrQ.pop_front();
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== expA || pc !== modelPc) begin
      miscompares++;
      $display("[TB] FAIL rst_refetch: got req=%0b addr=%h pc=%h, want req=1 addr=%h pc=%h", mem_req_o, mem_addr_o, pc, expA, modelPc);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h24010001;
    modelPc = modelPc + 32'd4;
    next(); mem_ack_i = 1'b0; settle();
  endtask

  task automatic test_align();
    expAddrQ.push_back({modelPc[31:2], 2'b00});
    next(); settle();
    expA = expAddrQ.pop_front();
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== expA) begin
      miscompares++;
      $display("[TB] FAIL align_req: got req=%0b addr=%h, want req=1 addr=%h", mem_req_o, mem_addr_o, expA);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h10000004; branch_flag_i = 1'b1; branch_target_address_i = 32'h80000012;
    modelPc = 32'h80000012;
    next(); mem_ack_i = 1'b0; branch_flag_i = 1'b0; settle();
`ifdef IF_ALIGN_CHECK_EN
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (pc !== modelPc || mem_req_o !== 1'b0 || stallreq_o !== 1'b0 || inst_o !== 32'h0 || excepttype_o !== 32'h00002000) begin
        miscompares++;
        $display("[TB] FAIL align_trap%0d: got pc=%h req=%0b stallreq=%0b inst=%h exc=%h, want %h 0 0 0 00002000",
                 i, pc, mem_req_o, stallreq_o, inst_o, excepttype_o, modelPc);
      end
      next(); settle();
    end
    flush = 1'b1; new_pc = RESET_PC; modelPc = RESET_PC;
    next(); flush = 1'b0; settle();
    vectors++;
    if (excepttype_o !== 32'h0 || stallreq_o !== 1'b1 || pc !== modelPc) begin
      miscompares++;
      $display("[TB] FAIL align_exit: got exc=%h stallreq=%0b pc=%h, want 0 1 %h", excepttype_o, stallreq_o, pc, modelPc);
    end
`else
    vectors++;
    if (pc !== modelPc || excepttype_o !== 32'h0 || stallreq_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL align_none: got pc=%h exc=%h stallreq=%0b, want %h 0 1", pc, excepttype_o, stallreq_o, modelPc);
    end
    expAddrQ.push_back({modelPc[31:2], 2'b00});
    next(); settle();
    expA = expAddrQ.pop_front();
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== expA || excepttype_o !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL align_masked_req: got req=%0b addr=%h exc=%h, want req=1 addr=%h exc=0", mem_req_o, mem_addr_o, excepttype_o, expA);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h0;
    next(); mem_ack_i = 1'b0; settle();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delayed_ack();
    test_hold();
    test_flush();
    test_branch();
    test_wrap();
    test_reset_mid_busy();
    test_align();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
